// File: rtl/read_execute_pipeline_regs.sv
// Read->execute (R1) and execute->write-back (R2) pipeline registers, forwarding muxes and HALT FSM.
// Optional macro STALL_COUNTER_EN adds a saturating bubble-cycle counter on stall_count.
`ifndef NOP
`define NOP 7'h00
`endif
`ifndef LOAD
`define LOAD 7'h03
`endif
`ifndef HALT
`define HALT 7'h7F
`endif

module read_execute_pipeline_regs #(
  parameter int D_BITS = 32,
  parameter int A_BITS = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        id_opcode,
  input  logic [A_BITS-1:0] id_dest,
  input  logic              id_write_en,
  input  logic [D_BITS-1:0] id_src1_data,
  input  logic [D_BITS-1:0] id_src2_data,
  input  logic              bubble,
  input  logic              forward1_r1,
  input  logic              forward2_r1,
  input  logic              forward1_r2,
  input  logic              forward2_r2,
  input  logic              flush,
  input  logic [D_BITS-1:0] r1_result,
  output logic [6:0]        ex_opcode,
  output logic [D_BITS-1:0] ex_operand1,
  output logic [D_BITS-1:0] ex_operand2,
  output logic [A_BITS-1:0] r1_destination,
  output logic              write_en,
  output logic              read,
  output logic [A_BITS-1:0] r2_destination,
  output logic              r2_write_en,
  output logic [D_BITS-1:0] wb_data,
  output logic              fetch_stall,
  output logic              halted,
  output logic [15:0]       stall_count
);

  typedef enum logic {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [6:0]          opcode_q, opcode_d;
  logic [D_BITS-1:0]   op1_q, op1_d, op2_q, op2_d;
  logic [A_BITS-1:0]   dest_q, dest_d;
  logic                we_q, we_d;
  logic [A_BITS-1:0]   r2_dest_q;
  logic                r2_we_q;
  logic [D_BITS-1:0]   wb_q;
  logic [D_BITS-1:0]   mux1_s, mux2_s;
  logic                capture_s;

  // R1 forward beats R2 forward: it is the younger producer.
  always_comb begin
    mux1_s = forward1_r1 ? r1_result : (forward1_r2 ? wb_q : id_src1_data);
    mux2_s = forward2_r1 ? r1_result : (forward2_r2 ? wb_q : id_src2_data);
  end

  always_comb begin
    capture_s = ~flush & (state_q == ST_RUN) & ~bubble;
    opcode_d  = `NOP;
    dest_d    = {A_BITS{1'b0}};
    we_d      = 1'b0;
    op1_d     = {D_BITS{1'b0}};
    op2_d     = {D_BITS{1'b0}};
    state_d   = state_q;
    if (capture_s) begin
      opcode_d = id_opcode;
      dest_d   = id_dest;
      we_d     = id_write_en;
      op1_d    = mux1_s;
      op2_d    = mux2_s;
      if (id_opcode == `HALT) begin
        state_d = ST_HALTED;
      end else begin
        state_d = state_q;
      end
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opcode_q  <= `NOP;
      dest_q    <= {A_BITS{1'b0}};
      we_q      <= 1'b0;
      op1_q     <= {D_BITS{1'b0}};
      op2_q     <= {D_BITS{1'b0}};
      r2_dest_q <= {A_BITS{1'b0}};
      r2_we_q   <= 1'b0;
      wb_q      <= {D_BITS{1'b0}};
    end else begin
      opcode_q  <= opcode_d;
      dest_q    <= dest_d;
      we_q      <= we_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      r2_dest_q <= dest_q;
      r2_we_q   <= we_q;
      wb_q      <= r1_result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:    state_q <= state_d;
        ST_HALTED: state_q <= ST_HALTED;
        default:   state_q <= ST_RUN;
      endcase
    end
  end

`ifdef STALL_COUNTER_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    if (bubble && !flush && (state_q == ST_RUN) && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
`else
  assign stall_count = 16'd0;
`endif

  assign ex_opcode      = opcode_q;
  assign ex_operand1    = op1_q;
  assign ex_operand2    = op2_q;
  assign r1_destination = dest_q;
  assign write_en       = we_q;
  assign read           = (opcode_q == `LOAD);
  assign r2_destination = r2_dest_q;
  assign r2_write_en    = r2_we_q;
  assign wb_data        = wb_q;
  assign halted         = (state_q == ST_HALTED);
  assign fetch_stall    = (bubble & ~flush) | (state_q == ST_HALTED);

endmodule

// File: tb/tb_read_execute_pipeline_regs.sv
// Directed table-driven bench for read_execute_pipeline_regs plus hand-written halt/reset/counter sequences.
`ifndef NOP
`define NOP 7'h00
`endif
`ifndef LOAD
`define LOAD 7'h03
`endif
`ifndef HALT
`define HALT 7'h7F
`endif

module tb_read_execute_pipeline_regs;
  localparam int D = 32;
  localparam int A = 3;
  localparam logic [6:0] ADD = 7'h33;
  localparam logic [6:0] SUB = 7'h3B;

  logic clk = 1'b0;
  logic rst;
  logic [6:0] id_opcode;
  logic [A-1:0] id_dest;
  logic id_write_en;
  logic [D-1:0] id_src1_data, id_src2_data;
  logic bubble, forward1_r1, forward2_r1, forward1_r2, forward2_r2, flush;
  logic [D-1:0] r1_result;
  logic [6:0] ex_opcode;
  logic [D-1:0] ex_operand1, ex_operand2;
  logic [A-1:0] r1_destination, r2_destination;
  logic write_en, read, r2_write_en, fetch_stall, halted;
  logic [D-1:0] wb_data;
  logic [15:0] stall_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  read_execute_pipeline_regs #(.D_BITS(D), .A_BITS(A)) dut (
    .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_dest(id_dest),
    .id_write_en(id_write_en), .id_src1_data(id_src1_data), .id_src2_data(id_src2_data),
    .bubble(bubble), .forward1_r1(forward1_r1), .forward2_r1(forward2_r1),
    .forward1_r2(forward1_r2), .forward2_r2(forward2_r2), .flush(flush),
    .r1_result(r1_result), .ex_opcode(ex_opcode), .ex_operand1(ex_operand1),
    .ex_operand2(ex_operand2), .r1_destination(r1_destination), .write_en(write_en),
    .read(read), .r2_destination(r2_destination), .r2_write_en(r2_write_en),
    .wb_data(wb_data), .fetch_stall(fetch_stall), .halted(halted), .stall_count(stall_count)
  );

  typedef struct {
    logic [6:0]   op;
    logic [A-1:0] dest;
    logic         we;
    logic [D-1:0] s1, s2;
    logic         bub, f1r1, f1r2, f2r1, f2r2, fl;
    logic [D-1:0] r1r;
    logic [6:0]   e_op;
    logic [D-1:0] e_op1, e_op2;
    logic [A-1:0] e_dest;
    logic         e_we;
    logic         e_fs;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    id_opcode = ADD; id_dest = 3'd0; id_write_en = 1'b0;
    id_src1_data = 32'd0; id_src2_data = 32'd0;
    bubble = 1'b0; flush = 1'b0; r1_result = 32'd0;
    forward1_r1 = 1'b0; forward2_r1 = 1'b0; forward1_r2 = 1'b0; forward2_r2 = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [6:0] op, input logic [A-1:0] dest, input logic we,
                              input logic [D-1:0] s1, input logic [D-1:0] s2,
                              input logic bub, input logic f1r1, input logic f1r2,
                              input logic f2r1, input logic f2r2, input logic fl,
                              input logic [D-1:0] r1r, input logic [6:0] e_op,
                              input logic [D-1:0] e_op1, input logic [D-1:0] e_op2,
                              input logic [A-1:0] e_dest, input logic e_we, input logic e_fs);
    vec_t v;
    v.op = op; v.dest = dest; v.we = we; v.s1 = s1; v.s2 = s2;
    v.bub = bub; v.f1r1 = f1r1; v.f1r2 = f1r2; v.f2r1 = f2r1; v.f2r2 = f2r2; v.fl = fl;
    v.r1r = r1r; v.e_op = e_op; v.e_op1 = e_op1; v.e_op2 = e_op2;
    v.e_dest = e_dest; v.e_we = e_we; v.e_fs = e_fs;
    return v;
  endfunction

  initial begin
    logic [A-1:0] prev_dest;
    logic         prev_we;
    logic [15:0]  exp_cnt;

    // wb_data seen by vector i is r1_result of vector i-1 (0 right after reset)
    vecs[0] = mk(ADD, 3'd3, 1'b1, 32'h1, 32'h2, 0,0,0,0,0,0, 32'h0,  ADD, 32'h1, 32'h2, 3'd3, 1'b1, 1'b0);
    vecs[1] = mk(ADD, 3'd4, 1'b1, 32'h11, 32'h22, 0,1,0,0,0,0, 32'h55, ADD, 32'h55, 32'h22, 3'd4, 1'b1, 1'b0);
    vecs[2] = mk(SUB, 3'd5, 1'b1, 32'h7, 32'h8, 0,0,0,1,1,0, 32'hA, SUB, 32'h7, 32'hA, 3'd5, 1'b1, 1'b0);
    vecs[3] = mk(ADD, 3'd6, 1'b1, 32'h9, 32'h99, 0,0,1,0,1,0, 32'hB, ADD, 32'hA, 32'hA, 3'd6, 1'b1, 1'b0);
    vecs[4] = mk(`LOAD, 3'd2, 1'b1, 32'h40, 32'h0, 0,0,0,0,0,0, 32'h0, `LOAD, 32'h40, 32'h0, 3'd2, 1'b1, 1'b0);
    vecs[5] = mk(ADD, 3'd7, 1'b1, 32'h3, 32'h4, 1,0,0,0,0,0, 32'h77, `NOP, 32'h0, 32'h0, 3'd0, 1'b0, 1'b1);
    vecs[6] = mk(ADD, 3'd7, 1'b1, 32'h3, 32'h4, 0,0,1,0,0,0, 32'h0, ADD, 32'h77, 32'h4, 3'd7, 1'b1, 1'b0);
    vecs[7] = mk(ADD, 3'd1, 1'b1, 32'h5, 32'h6, 1,0,0,0,0,1, 32'h5, `NOP, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
    vecs[8] = mk(ADD, 3'd1, 1'b1, 32'h5, 32'h6, 0,0,0,0,0,1, 32'h6, `NOP, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0);
    vecs[9] = mk(ADD, 3'd1, 1'b0, 32'hDEAD, 32'hBEEF, 0,0,0,0,0,0, 32'h9, ADD, 32'hDEAD, 32'hBEEF, 3'd1, 1'b0, 1'b0);

    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_opcode", {25'd0, ex_opcode}, {25'd0, `NOP});
    chk("rst_op1", ex_operand1, 32'h0);
    chk("rst_op2", ex_operand2, 32'h0);
    chk("rst_we", {31'd0, write_en}, 32'd0);
    chk("rst_r2we", {31'd0, r2_write_en}, 32'd0);
    chk("rst_wb", wb_data, 32'h0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_cnt", {16'd0, stall_count}, 32'd0);
    rst = 1'b0;

    prev_dest = 3'd0;
    prev_we = 1'b0;
    exp_cnt = 16'd0;
    for (int i = 0; i < 10; i++) begin
      id_opcode = vecs[i].op; id_dest = vecs[i].dest; id_write_en = vecs[i].we;
      id_src1_data = vecs[i].s1; id_src2_data = vecs[i].s2;
      bubble = vecs[i].bub; flush = vecs[i].fl; r1_result = vecs[i].r1r;
      forward1_r1 = vecs[i].f1r1; forward1_r2 = vecs[i].f1r2;
      forward2_r1 = vecs[i].f2r1; forward2_r2 = vecs[i].f2r2;
      #1;
      chk($sformatf("v%0d_fetch_stall", i), {31'd0, fetch_stall}, {31'd0, vecs[i].e_fs});
`ifdef STALL_COUNTER_EN
      if (vecs[i].bub && !vecs[i].fl) exp_cnt = exp_cnt + 16'd1;
`endif
      tick();
      chk($sformatf("v%0d_opcode", i), {25'd0, ex_opcode}, {25'd0, vecs[i].e_op});
      chk($sformatf("v%0d_op1", i), ex_operand1, vecs[i].e_op1);
      chk($sformatf("v%0d_op2", i), ex_operand2, vecs[i].e_op2);
      chk($sformatf("v%0d_dest", i), {29'd0, r1_destination}, {29'd0, vecs[i].e_dest});
      chk($sformatf("v%0d_we", i), {31'd0, write_en}, {31'd0, vecs[i].e_we});
      chk($sformatf("v%0d_read", i), {31'd0, read}, {31'd0, (vecs[i].e_op == `LOAD)});
      chk($sformatf("v%0d_r2dest", i), {29'd0, r2_destination}, {29'd0, prev_dest});
      chk($sformatf("v%0d_r2we", i), {31'd0, r2_write_en}, {31'd0, prev_we});
      chk($sformatf("v%0d_wb", i), wb_data, vecs[i].r1r);
      chk($sformatf("v%0d_cnt", i), {16'd0, stall_count}, {16'd0, exp_cnt});
      prev_dest = vecs[i].e_dest;
      prev_we = vecs[i].e_we;
    end

    // two more plain bubbles
    idle_inputs();
    bubble = 1'b1;
    tick();
    tick();
`ifdef STALL_COUNTER_EN
    chk("cnt_three", {16'd0, stall_count}, 32'd3);
    for (int k = 0; k < 65540; k++) tick();
    chk("cnt_sat", {16'd0, stall_count}, 32'h0000FFFF);
    bubble = 1'b0;
    tick();
    chk("cnt_sat_hold", {16'd0, stall_count}, 32'h0000FFFF);
`else
    chk("cnt_off", {16'd0, stall_count}, 32'd0);
`endif
    chk("bub_opcode", {25'd0, ex_opcode}, {25'd0, `NOP});

    // halt sequence
    idle_inputs();
    id_opcode = `HALT;
    tick();
    chk("halt_in_r1", {25'd0, ex_opcode}, {25'd0, `HALT});
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_fs", {31'd0, fetch_stall}, 32'd1);
    id_opcode = ADD; id_dest = 3'd5; id_write_en = 1'b1; id_src1_data = 32'h1234;
    for (int k = 0; k < 10; k++) begin
      bubble = (k == 3);
      r1_result = 32'h100 + k;
      tick();
      chk($sformatf("h%0d_opcode", k), {25'd0, ex_opcode}, {25'd0, `NOP});
      chk($sformatf("h%0d_we", k), {31'd0, write_en}, 32'd0);
      chk($sformatf("h%0d_fs", k), {31'd0, fetch_stall}, 32'd1);
      chk($sformatf("h%0d_halted", k), {31'd0, halted}, 32'd1);
      chk($sformatf("h%0d_wb", k), wb_data, 32'h100 + k);
    end
`ifdef STALL_COUNTER_EN
    chk("halt_cnt", {16'd0, stall_count}, 32'h0000FFFF);
`else
    chk("halt_cnt", {16'd0, stall_count}, 32'd0);
`endif
    bubble = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("unhalt_flag", {31'd0, halted}, 32'd0);
    chk("unhalt_opcode", {25'd0, ex_opcode}, {25'd0, `NOP});
    chk("unhalt_r2we", {31'd0, r2_write_en}, 32'd0);
    chk("unhalt_fs", {31'd0, fetch_stall}, 32'd0);
    chk("unhalt_cnt", {16'd0, stall_count}, 32'd0);
    tick();
    chk("resume_opcode", {25'd0, ex_opcode}, {25'd0, ADD});
    chk("resume_op1", ex_operand1, 32'h1234);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/read_execute_pipeline_regs.md
Name: read_execute_pipeline_regs

Overview:
- Pipeline register block between the read, execute and write-back stages of the step-1 pipelined processor.
- Consumes the hazard decisions (bubble, four forward selects) and applies them: forwarding operand muxes, NOP insertion and fetch stall.
- Holds the in-flight execute (R1) and write-back (R2) instruction state, and feeds R1/R2 destination, write enable and read status back to the dependency logic.
- Contains the HALT state machine.

Parameters:
- D_BITS, 32, operand/result data width.
- A_BITS, 3, register index width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- id_opcode  input  7  opcode of instruction in read stage.
- id_dest  input  A_BITS  destination register of read-stage instruction.
- id_write_en  input  1  read-stage instruction writes register file.
- id_src1_data  input  D_BITS  register-file value for source_1.
- id_src2_data  input  D_BITS  register-file value for source_2.
- bubble  input  1  load-use hazard; stall read/fetch one cycle.
- forward1_r1, forward2_r1  input  1 each  take operand 1 / operand 2 from r1_result.
- forward1_r2, forward2_r2  input  1 each  take operand 1 / operand 2 from R2 data.
- flush  input  1  taken branch in execute; kill read-stage instruction.
- r1_result  input  D_BITS  execute-stage result (ALU or memory data).
- ex_opcode  output  7  R1 opcode.
- ex_operand1, ex_operand2  output  D_BITS each  R1 operands.
- r1_destination  output  A_BITS  R1 destination register.
- write_en  output  1  R1 write enable.
- read  output  1  R1 holds a LOAD.
- r2_destination  output  A_BITS  R2 destination register.
- r2_write_en  output  1  R2 write enable.
- wb_data  output  D_BITS  R2 result; register-file write data and R2 forward source.
- fetch_stall  output  1  hold PC and read stage.
- halted  output  1  processor halted.
- stall_count  output  16  bubble cycle count (optional feature).

Behaviour:
- Reset (rst=1 at clk edge):
  - ex_opcode = `NOP; r1_destination = 0, write_en = 0.
  - ex_operand1/2 = 0.
  - r2_destination = 0, r2_write_en = 0, wb_data = 0.
  - FSM = RUN; stall_count = 0.
- Reset mid-operation discards all in-flight instructions, including from HALTED.
- Operand mux (combinational, captured into R1):
  - op1 = forward1_r1 ? r1_result : forward1_r2 ? wb_data : id_src1_data.
  - op2 is the same using the forward2_* selects and id_src2_data.
  - R1 has priority when both selects are set (younger result).
- R1 load rules, in priority order each cycle:
  1. rst
  2. flush -> NOP
  3. FSM = HALTED -> NOP
  4. bubble -> NOP
  5. otherwise capture id_* and the muxed operands.
- NOP load means: opcode = `NOP, write_en = 0, destination = 0, operands = 0.
- R2 advances every non-reset cycle and is never stalled:
  - r2_destination <= r1_destination.
  - r2_write_en <= write_en.
  - wb_data <= r1_result.
- read = (ex_opcode == `LOAD), combinational from R1.
- fetch_stall = bubble & ~flush, OR FSM = HALTED. Combinational; same cycle as bubble.
- Bubble latency:
  - The stalled instruction enters R1 one cycle later than normal.
  - Its operands are re-muxed on the accepting cycle with that cycle's forward selects.
- FSM states RUN and HALTED:
  - RUN -> HALTED when `HALT is captured into R1 (not flushed, not bubbled).
  - HALTED is left only by rst.
  - halted = 1 exactly when FSM = HALTED, registered: first high the cycle after `HALT enters R1.
  - R2 still drains in HALTED.
- Opcode encodings: `NOP, `HALT and `LOAD come from defines.v; the block decodes no other opcodes.

Optional Feature:
- Macro STALL_COUNTER_EN.
- Defined: stall_count increments by 1 on every clock where bubble=1, flush=0 and FSM = RUN. It saturates at 16'hFFFF and clears on rst.
- Undefined: stall_count tied to 0; no counter flops.

Test Plan:
- R1 forward: R1 ADD dest=3 with r1_result=0x55; read ADD src1=3, forward1_r1=1, id_src1_data=0x11 -> next cycle ex_operand1=0x55.
- Forward priority: forward2_r1=1 and forward2_r2=1, r1_result=0xA, wb_data=0xB -> ex_operand2=0xA. With only forward2_r2=1 -> 0xB.
- Bubble: LOAD dest=2 in R1 (read=1), bubble=1 for one cycle:
  - same cycle: fetch_stall=1.
  - next cycle: ex_opcode=`NOP, write_en=0; the LOAD reaches R2.
  - following cycle: the held instruction is captured with forward1_r2 giving wb_data.
- Flush vs bubble: flush=1 and bubble=1 together -> fetch_stall=0, R1=NOP, stall_count unchanged.
- Halt: `HALT captured -> halted=1 one cycle later and fetch_stall=1 every cycle; R1 stays NOP for 10 cycles. rst=1 one cycle -> halted=0, R1=NOP, r2_write_en=0.
- STALL_COUNTER_EN: 3 bubble cycles -> stall_count=3. Preload near saturation, apply 2 more bubbles -> stays 16'hFFFF. Macro undefined -> stall_count stays 0.
